// File: rtl/spart_driver_if.sv
// Spart processor-side control handshake: chip select, direction, address, and status strobes.
// The shared data bus stays a plain inout on the driver so tristate resolution is module-level.
interface spart_driver_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (
      output iocs,
      output iorw,
      output ioaddr,
      input  rda,
      input  tbr
   );

   modport slave (
      input  iocs,
      input  iorw,
      input  ioaddr,
      output rda,
      output tbr
   );
endinterface

// File: rtl/spart_driver.sv
// Bus initiator for the spart: programs the baud divisor from br_cfg, then echoes every
// received byte back to the transmitter and flags bytes lost to overrun.
module spart_driver (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     br_cfg,
   spart_driver_if.master bus,
   inout  wire  [7:0]     databus,
   output logic [7:0]     echo_byte,
   output logic           overrun
);

   localparam logic [15:0] DIV_4800  = 16'd10416;
   localparam logic [15:0] DIV_9600  = 16'd5208;
   localparam logic [15:0] DIV_19200 = 16'd2604;
   localparam logic [15:0] DIV_38400 = 16'd1302;

   typedef enum logic [2:0] {
      StInit,
      StCfgLow,
      StCfgHigh,
      StIdle,
      StRd,
      StWaitTbr,
      StWr
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cfg_q, cfg_d;
   logic        pend_q, pend_d;
   logic [7:0]  echo_q, echo_d;
   logic        overrun_q, overrun_d;
   logic [15:0] div;
   logic        drive;
   logic [7:0]  dout;

   always_comb begin
      unique case (cfg_q)
         2'b00:   div = DIV_4800;
         2'b01:   div = DIV_9600;
         2'b10:   div = DIV_19200;
         default: div = DIV_38400;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      echo_d    = echo_q;
      // A new byte arriving during RD belongs to the next read, so the set wins the clear.
      pend_d    = bus.rda | (pend_q & (state_q != StRd));
      overrun_d = overrun_q | (bus.rda & pend_q & (state_q != StRd));
      unique case (state_q)
         StInit: begin
            cfg_d   = br_cfg;
            state_d = StCfgLow;
         end
         StCfgLow:  state_d = StCfgHigh;
         StCfgHigh: state_d = StIdle;
         StIdle: begin
            if (br_cfg != cfg_q) begin
               cfg_d   = br_cfg;
               state_d = StCfgLow;
            end else if (pend_q) begin
               state_d = StRd;
            end
         end
         StRd: begin
            echo_d  = databus;
            state_d = StWaitTbr;
         end
         StWaitTbr: if (bus.tbr) state_d = StWr;
         StWr:      state_d = StIdle;
         default:   state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StInit;
         cfg_q     <= 2'b00;
         pend_q    <= 1'b0;
         echo_q    <= 8'h00;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         pend_q    <= pend_d;
         echo_q    <= echo_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      bus.iocs   = 1'b0;
      bus.iorw   = 1'b1;
      bus.ioaddr = 2'b00;
      drive      = 1'b0;
      dout       = 8'h00;
      unique case (state_q)
         StCfgLow: begin
            bus.iocs   = 1'b1;
            bus.iorw   = 1'b0;
            bus.ioaddr = 2'b10;
            drive      = 1'b1;
            dout       = div[7:0];
         end
         StCfgHigh: begin
            bus.iocs   = 1'b1;
            bus.iorw   = 1'b0;
            bus.ioaddr = 2'b11;
            drive      = 1'b1;
            dout       = div[15:8];
         end
         StRd: bus.iocs = 1'b1;
         StWr: begin
            bus.iocs = 1'b1;
            bus.iorw = 1'b0;
            drive    = 1'b1;
            dout     = echo_q;
         end
         default: ;
      endcase
   end

   assign databus   = drive ? dout : 8'hzz;
   assign echo_byte = echo_q;
   assign overrun   = overrun_q;

endmodule
